motor_ramp_ctrl: RTL and testbench
==================================

Name: motor_ramp_ctrl

Overview:
Sequencer between the travel state machine (enable/direct requests) and the DC-motor PWM generator driving the bridge.
- Converts on/off/direction requests into a soft-start/soft-stop duty ramp.
- Inserts a dead time on every stop or reversal.
- Forces an immediate stop when the limit switch in the direction of travel trips.

Parameters:
DUTY_W, 8, width of duty output
DUTY_MAX, 255, full-speed duty; ramp saturates here (must be >=1 and < 2^DUTY_W)
STEP_DIV, 1000, clocks per one-LSB duty step during ramps (>=1)
DEAD_CYC, 5000, clocks with bridge disabled after any stop (>=1)

Ports:
sclk  in  1  system clock
s_rst  in  1  synchronous reset, active-high
enable  in  1  run request from state machine (level)
direct  in  1  requested direction; 1 = toward right limit, 0 = toward left limit
limit_r  in  1  right limit switch, active-high, already synchronised
limit_l  in  1  left limit switch, active-high, already synchronised
duty  out  DUTY_W  duty command to PWM generator
pwm_en  out  1  bridge enable to PWM generator
pwm_dir  out  1  latched travel direction to PWM generator
busy  out  1  high in any state other than IDLE
limit_hit  out  1  one-cycle pulse on an emergency stop

Behaviour:
- Reset (s_rst=1 at a sclk edge):
  - state=IDLE; duty=0, pwm_en=0, pwm_dir=0, busy=0, limit_hit=0.
  - Prescaler and dead counter cleared.
  - Applies mid-ramp with no ramp-down.
- All outputs are registered.
- lim_fwd = pwm_dir ? limit_r : limit_l. This is the switch ahead of current travel.
- Prescaler:
  - Counts 0..STEP_DIV-1 and emits tick on STEP_DIV-1.
  - Cleared on every state entry, so the first tick comes STEP_DIV cycles after entry.
- States:
  - IDLE:
    - duty=0, pwm_en=0.
    - If enable=1 and the switch ahead of direct is clear (direct ? !limit_r : !limit_l), then next cycle: pwm_dir<=direct, pwm_en<=1, go RAMP_UP.
    - If enable=1 with that switch asserted: stay IDLE, no limit_hit.
  - RAMP_UP:
    - On each tick, duty<=duty+1.
    - When duty+1==DUTY_MAX on a tick, go RUN in the same cycle.
    - If enable=0 or direct!=pwm_dir: go RAMP_DOWN and keep the current duty.
  - RUN:
    - duty holds at DUTY_MAX.
    - If enable=0 or direct!=pwm_dir: go RAMP_DOWN.
  - RAMP_DOWN:
    - On each tick, duty<=duty-1.
    - When duty reaches 0 (or is 0 on entry): pwm_en<=0, go DEAD.
    - Requests are ignored until IDLE is reached, including enable re-asserting.
  - DEAD:
    - duty=0, pwm_en=0.
    - Counts DEAD_CYC cycles, then goes to IDLE.
    - Requests are ignored.
    - pwm_dir holds its last value.
- Emergency stop:
  - In RAMP_UP, RUN or RAMP_DOWN, lim_fwd=1 has priority over every other condition.
  - Next cycle: duty<=0, pwm_en<=0, limit_hit<=1 for one cycle, go DEAD.
- Switch behind travel (the opposite switch) is ignored while moving.
- Reversal: direct toggling while running gives RAMP_DOWN → DEAD → IDLE → RAMP_UP with the new direction. This holds only if enable is still 1 at IDLE.
- Arithmetic:
  - duty never exceeds DUTY_MAX and never goes below 0.
  - Counters are sized from the parameters, with no wrap inside a phase.
- Latency from request to first nonzero duty = 1 (IDLE→RAMP_UP) + STEP_DIV cycles.

Test Plan:
(Bench parameters: DUTY_MAX=8, STEP_DIV=4, DEAD_CYC=6.)
1. Reset held with random inputs → all outputs 0. Release with enable=1, direct=1, limits 0 → pwm_en=1, pwm_dir=1 one cycle later; duty=1 four cycles after that; duty=8 and state RUN 32 cycles after RAMP_UP entry.
2. From RUN, drop enable → duty 8→0 in 4-cycle steps. pwm_en falls with duty=0, then 6 cycles in DEAD, then busy=0.
3. From RUN with direct=1, toggle direct to 0 → full ramp-down and dead time, then pwm_dir=0, ramp up from 1. pwm_en=0 throughout the dead window.
4. Ramping up with direct=1 at duty=3, assert limit_r → next cycle duty=0, pwm_en=0, limit_hit high for exactly 1 cycle, then DEAD for 6 cycles. Assert limit_l in the same travel instead → no effect.
5. IDLE, enable=1, direct=0, limit_l=1 → stays IDLE, pwm_en=0, limit_hit=0. Release limit_l → RAMP_UP next cycle.
6. Assert s_rst at duty=5 in RAMP_DOWN → next cycle duty=0, pwm_en=0, busy=0. Re-enable → normal start from 0.

Source files
------------

// File: rtl/motor_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for a DC-motor bridge: ramps the PWM duty,
// enforces a dead time after every stop and stops at once on the forward limit switch.
module motor_ramp_ctrl #(
  parameter int unsigned DUTY_W   = 8,
  parameter int unsigned DUTY_MAX = 255,
  parameter int unsigned STEP_DIV = 1000,
  parameter int unsigned DEAD_CYC = 5000
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              enable,
  input  logic              direct,
  input  logic              limit_r,
  input  logic              limit_l,
  output logic [DUTY_W-1:0] duty,
  output logic              pwm_en,
  output logic              pwm_dir,
  output logic              busy,
  output logic              limit_hit
);

  localparam int unsigned PrescW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned DeadW  = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  localparam logic [PrescW-1:0] PrescLast = PrescW'(STEP_DIV - 1);
  localparam logic [PrescW-1:0] PrescOne  = PrescW'(1);
  localparam logic [DeadW-1:0]  DeadLast  = DeadW'(DEAD_CYC - 1);
  localparam logic [DeadW-1:0]  DeadOne   = DeadW'(1);
  localparam logic [DUTY_W-1:0] DutyMax   = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DutyOne   = DUTY_W'(1);
  localparam logic [DUTY_W-1:0] DutyZero  = '0;

  typedef enum logic [2:0] {
    StIdle,
    StRampUp,
    StRun,
    StRampDown,
    StDead
  } state_e;

  state_e              state_q, state_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic                pwm_en_q, pwm_en_d;
  logic                pwm_dir_q, pwm_dir_d;
  logic                busy_q;
  logic                limit_hit_q, limit_hit_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [DeadW-1:0]    dead_q, dead_d;

  logic tick;
  logic lim_fwd;
  logic moving;
  logic stop_req;

  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    pwm_en_d    = pwm_en_q;
    pwm_dir_d   = pwm_dir_q;
    limit_hit_d = 1'b0;

    tick     = (presc_q == PrescLast);
    lim_fwd  = pwm_dir_q ? limit_r : limit_l;
    moving   = (state_q == StRampUp) || (state_q == StRun) || (state_q == StRampDown);
    stop_req = !enable || (direct != pwm_dir_q);

    // The switch ahead of travel overrides everything while the bridge is driven.
    if (moving && lim_fwd) begin
      duty_d      = DutyZero;
      pwm_en_d    = 1'b0;
      limit_hit_d = 1'b1;
      state_d     = StDead;
    end else begin
      unique case (state_q)
        StIdle: begin
          duty_d   = DutyZero;
          pwm_en_d = 1'b0;
          if (enable && !(direct ? limit_r : limit_l)) begin
            pwm_dir_d = direct;
            pwm_en_d  = 1'b1;
            state_d   = StRampUp;
          end
        end
        StRampUp: begin
          if (stop_req) begin
            state_d = StRampDown;
          end else if (tick) begin
            duty_d = duty_q + DutyOne;
            if (duty_d == DutyMax) state_d = StRun;
          end
        end
        StRun: begin
          duty_d = DutyMax;
          if (stop_req) state_d = StRampDown;
        end
        StRampDown: begin
          if (duty_q == DutyZero) begin
            pwm_en_d = 1'b0;
            state_d  = StDead;
          end else if (tick) begin
            duty_d = duty_q - DutyOne;
            if (duty_q == DutyOne) begin
              pwm_en_d = 1'b0;
              state_d  = StDead;
            end
          end
        end
        StDead: begin
          duty_d   = DutyZero;
          pwm_en_d = 1'b0;
          if (dead_q == DeadLast) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    // Prescaler restarts on every state entry so each phase gets a full first step.
    presc_d = ((state_d != state_q) || tick) ? '0 : presc_q + PrescOne;
    dead_d  = (state_q == StDead) ? dead_q + DeadOne : '0;
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q     <= StIdle;
      duty_q      <= '0;
      pwm_en_q    <= 1'b0;
      pwm_dir_q   <= 1'b0;
      busy_q      <= 1'b0;
      limit_hit_q <= 1'b0;
      presc_q     <= '0;
      dead_q      <= '0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      pwm_en_q    <= pwm_en_d;
      pwm_dir_q   <= pwm_dir_d;
      busy_q      <= (state_d != StIdle);
      limit_hit_q <= limit_hit_d;
      presc_q     <= presc_d;
      dead_q      <= dead_d;
    end
  end

  assign duty      = duty_q;
  assign pwm_en    = pwm_en_q;
  assign pwm_dir   = pwm_dir_q;
  assign busy      = busy_q;
  assign limit_hit = limit_hit_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Scoreboard bench for motor_ramp_ctrl: expected output snapshots are queued against
// absolute cycle numbers when stimulus is driven and compared when that cycle arrives.
module tb_motor_ramp_ctrl;

  localparam int unsigned DutyW   = 8;
  localparam int unsigned DutyMax = 8;
  localparam int unsigned StepDiv = 4;
  localparam int unsigned DeadCyc = 6;

  logic             sclk;
  logic             s_rst;
  logic             enable;
  logic             direct;
  logic             limit_r;
  logic             limit_l;
  logic [DutyW-1:0] duty;
  logic             pwm_en;
  logic             pwm_dir;
  logic             busy;
  logic             limit_hit;

  motor_ramp_ctrl #(
    .DUTY_W  (DutyW),
    .DUTY_MAX(DutyMax),
    .STEP_DIV(StepDiv),
    .DEAD_CYC(DeadCyc)
  ) u_dut (
    .sclk     (sclk),
    .s_rst    (s_rst),
    .enable   (enable),
    .direct   (direct),
    .limit_r  (limit_r),
    .limit_l  (limit_l),
    .duty     (duty),
    .pwm_en   (pwm_en),
    .pwm_dir  (pwm_dir),
    .busy     (busy),
    .limit_hit(limit_hit)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  typedef struct {
    int unsigned cyc;
    logic [11:0] val;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cyc;
  int unsigned n_checks;
  int unsigned n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  // Snapshot layout: {duty, pwm_en, pwm_dir, busy, limit_hit}
  function automatic void expect_at(input int unsigned c, input string tag,
                                    input int unsigned d, input logic en, input logic dir,
                                    input logic bsy, input logic hit);
    exp_t e;
    e.cyc = c;
    e.val = {DutyW'(d), en, dir, bsy, hit};
    e.tag = tag;
    sb_q.push_back(e);
  endfunction

  always @(posedge sclk) begin
    #1;
    n_cyc++;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == n_cyc) begin
        check_eq(sb_q[i].tag, {20'd0, duty, pwm_en, pwm_dir, busy, limit_hit},
                 {20'd0, sb_q[i].val});
        sb_q.delete(i);
      end else if (sb_q[i].cyc < n_cyc) begin
        check_eq({sb_q[i].tag, "_missed"}, 32'd0, 32'd1);
        sb_q.delete(i);
      end
    end
  end

  task automatic wait_until(input int unsigned c);
    while (n_cyc < c) @(negedge sclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int unsigned e0, r0, d0, s0, m0, u0, b0, v0, q0;

  initial begin
    n_cyc = 0; n_checks = 0; n_fail = 0;
    s_rst = 1'b1; enable = 1'b0; direct = 1'b0; limit_r = 1'b0; limit_l = 1'b0;

    // 1: reset with random inputs, then start toward the right limit
    for (int i = 0; i < 4; i++) begin
      @(negedge sclk);
      {enable, direct, limit_r, limit_l} = 4'($urandom);
      expect_at(n_cyc + 1, "reset", 0, 0, 0, 0, 0);
    end
    @(negedge sclk);
    s_rst = 1'b0; enable = 1'b1; direct = 1'b1; limit_r = 1'b0; limit_l = 1'b0;
    e0 = n_cyc + 1;
    expect_at(e0, "start", 0, 1, 1, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      expect_at(e0 + 4 * k - 1, "up_pre", k - 1, 1, 1, 1, 0);
      expect_at(e0 + 4 * k, "up_step", k, 1, 1, 1, 0);
    end
    expect_at(e0 + 33, "run_hold", 8, 1, 1, 1, 0);
    wait_until(e0 + 34);

    // 2: drop enable from RUN
    enable = 1'b0;
    r0 = n_cyc + 1;
    for (int k = 1; k <= 8; k++) begin
      expect_at(r0 + 4 * k - 1, "down_pre", 9 - k, 1, 1, 1, 0);
      expect_at(r0 + 4 * k, "down_step", 8 - k, (k != 8), 1, 1, 0);
    end
    d0 = r0 + 32;
    for (int j = 1; j < 6; j++) expect_at(d0 + j, "dead", 0, 0, 1, 1, 0);
    expect_at(d0 + 6, "dead_done", 0, 0, 1, 0, 0);
    wait_until(d0 + 7);

    // 3: reversal from RUN
    enable = 1'b1; direct = 1'b1;
    s0 = n_cyc + 1;
    expect_at(s0, "rev_start", 0, 1, 1, 1, 0);
    expect_at(s0 + 32, "rev_run", 8, 1, 1, 1, 0);
    wait_until(s0 + 33);
    direct = 1'b0;
    m0 = n_cyc + 1;
    expect_at(m0, "rev_down", 8, 1, 1, 1, 0);
    d0 = m0 + 32;
    expect_at(d0, "rev_zero", 0, 0, 1, 1, 0);
    for (int j = 1; j < 6; j++) expect_at(d0 + j, "rev_dead", 0, 0, 1, 1, 0);
    expect_at(d0 + 6, "rev_idle", 0, 0, 1, 0, 0);
    expect_at(d0 + 7, "rev_newdir", 0, 1, 0, 1, 0);
    expect_at(d0 + 10, "rev_pre", 0, 1, 0, 1, 0);
    expect_at(d0 + 11, "rev_first", 1, 1, 0, 1, 0);
    wait_until(d0 + 11);
    enable = 1'b0;
    expect_at(d0 + 12, "rev_stop", 1, 1, 0, 1, 0);
    expect_at(d0 + 15, "rev_stop_pre", 1, 1, 0, 1, 0);
    expect_at(d0 + 16, "rev_stop_zero", 0, 0, 0, 1, 0);
    expect_at(d0 + 21, "rev_stop_dead", 0, 0, 0, 1, 0);
    expect_at(d0 + 22, "rev_stop_idle", 0, 0, 0, 0, 0);
    wait_until(d0 + 22);

    // 4: rear switch ignored, forward switch trips mid-ramp
    enable = 1'b1; direct = 1'b1;
    u0 = n_cyc + 1;
    expect_at(u0, "lim_start", 0, 1, 1, 1, 0);
    wait_until(u0 + 5);
    limit_l = 1'b1;
    expect_at(u0 + 8, "rear_ignored", 2, 1, 1, 1, 0);
    expect_at(u0 + 12, "rear_ignored3", 3, 1, 1, 1, 0);
    wait_until(u0 + 13);
    limit_r = 1'b1;
    expect_at(u0 + 14, "estop", 0, 0, 1, 1, 1);
    expect_at(u0 + 15, "estop_pulse", 0, 0, 1, 1, 0);
    expect_at(u0 + 19, "estop_dead", 0, 0, 1, 1, 0);
    expect_at(u0 + 20, "estop_idle", 0, 0, 1, 0, 0);
    wait_until(u0 + 15);
    enable = 1'b0; limit_l = 1'b0; limit_r = 1'b0;
    wait_until(u0 + 21);

    // 5: start blocked by the switch ahead of the requested direction
    enable = 1'b1; direct = 1'b0; limit_l = 1'b1;
    b0 = n_cyc;
    for (int j = 1; j <= 3; j++) expect_at(b0 + j, "blocked", 0, 0, 1, 0, 0);
    wait_until(b0 + 3);
    limit_l = 1'b0;
    v0 = n_cyc + 1;
    expect_at(v0, "unblocked", 0, 1, 0, 1, 0);
    expect_at(v0 + 4, "unblocked_first", 1, 1, 0, 1, 0);
    wait_until(v0 + 33);

    // 6: synchronous reset in the middle of a ramp-down
    enable = 1'b0;
    q0 = n_cyc + 1;
    expect_at(q0, "rst_down", 8, 1, 0, 1, 0);
    expect_at(q0 + 12, "rst_at5", 5, 1, 0, 1, 0);
    wait_until(q0 + 12);
    s_rst = 1'b1;
    expect_at(q0 + 13, "rst_mid", 0, 0, 0, 0, 0);
    wait_until(q0 + 13);
    s_rst = 1'b0; enable = 1'b1; direct = 1'b1;
    expect_at(q0 + 14, "rst_restart", 0, 1, 1, 1, 0);
    expect_at(q0 + 17, "rst_pre", 0, 1, 1, 1, 0);
    expect_at(q0 + 18, "rst_first", 1, 1, 1, 1, 0);
    wait_until(q0 + 19);

    check_eq("leftover", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
